// File: rtl/lamp_fpu_sqrt_ctrl.sv
// Issue/retire controller around the lampFPU sqrt core: classifies a bfloat16 operand, resolves specials locally,
// drives the core for finite operands and returns the packed result. Optional macro: LAMP_SQRT_CTRL_FTZ_EN.
module lamp_fpu_sqrt_ctrl #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [15:0] QNAN_PATTERN   = 16'h7FC0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [15:0] op_i,
    input  logic        inv_i,
    output logic        doSqrt_o,
    output logic        invSqrt_o,
    output logic        signum_op_o,
    output logic [7:0]  extExp_op_o,
    output logic [7:0]  extMant_op_o,
    output logic        isZero_op_o,
    output logic        isInf_op_o,
    output logic        isSNAN_op_o,
    output logic        isQNAN_op_o,
    input  logic        valid_i,
    input  logic        s_res_i,
    input  logic [7:0]  e_res_i,
    input  logic [6:0]  f_res_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [15:0] res_o,
    output logic        invalid_o,
    output logic        divzero_o,
    output logic        timeout_o
);

`ifdef LAMP_SQRT_CTRL_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic          inv_reg, inv_next;
    logic          sign_reg, sign_next;
    logic [7:0]    ext_exp_reg, ext_exp_next;
    logic [7:0]    ext_mant_reg, ext_mant_next;
    logic          is_zero_reg, is_zero_next;
    logic          is_inf_reg, is_inf_next;
    logic          is_snan_reg, is_snan_next;
    logic          is_qnan_reg, is_qnan_next;
    logic [15:0]   res_reg, res_next;
    logic          invalid_reg, invalid_next;
    logic          divzero_reg, divzero_next;
    logic          timeout_reg, timeout_next;
    logic [CW-1:0] count_reg, count_next;

    logic       sign_in;
    logic [7:0] exp_in;
    logic [6:0] frac_in;
    logic       nan_in, qnan_in, snan_in, inf_in, sub_in, zero_in;
    logic [15:0] core_word;

    assign sign_in = op_i[15];
    assign exp_in  = op_i[14:7];
    assign frac_in = op_i[6:0];
    assign nan_in  = (exp_in == 8'hFF) && (frac_in != 7'd0);
    assign qnan_in = nan_in && frac_in[6];
    assign snan_in = nan_in && !frac_in[6];
    assign inf_in  = (exp_in == 8'hFF) && (frac_in == 7'd0);
    assign sub_in  = (exp_in == 8'h00) && (frac_in != 7'd0);
    assign zero_in = ((exp_in == 8'h00) && (frac_in == 7'd0)) || (FTZ && sub_in);

    // Flush-to-zero of core results keeps only the sign when the exponent underflows to zero.
    assign core_word = (FTZ && (e_res_i == 8'h00)) ? {s_res_i, 15'd0} : {s_res_i, e_res_i, f_res_i};

    always_comb begin
        state_next    = state_reg;
        inv_next      = inv_reg;
        sign_next     = sign_reg;
        ext_exp_next  = ext_exp_reg;
        ext_mant_next = ext_mant_reg;
        is_zero_next  = is_zero_reg;
        is_inf_next   = is_inf_reg;
        is_snan_next  = is_snan_reg;
        is_qnan_next  = is_qnan_reg;
        res_next      = res_reg;
        invalid_next  = invalid_reg;
        divzero_next  = divzero_reg;
        timeout_next  = timeout_reg;
        count_next    = count_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    inv_next      = inv_i;
                    sign_next     = sign_in;
                    ext_exp_next  = (sub_in && !FTZ) ? 8'h01 : exp_in;
                    ext_mant_next = {(exp_in != 8'h00), frac_in};
                    is_zero_next  = zero_in;
                    is_inf_next   = inf_in;
                    is_snan_next  = snan_in;
                    is_qnan_next  = qnan_in;
                    invalid_next  = 1'b0;
                    divzero_next  = 1'b0;
                    timeout_next  = 1'b0;
                    count_next    = '0;
                    state_next    = DONE;
                    if (snan_in) begin
                        res_next     = QNAN_PATTERN;
                        invalid_next = 1'b1;
                    end else if (qnan_in) begin
                        res_next = QNAN_PATTERN;
                    end else if (zero_in) begin
                        if (inv_i) begin
                            res_next     = 16'h7F80;
                            divzero_next = 1'b1;
                        end else begin
                            res_next = {sign_in, 15'd0};
                        end
                    end else if (sign_in) begin
                        res_next     = QNAN_PATTERN;
                        invalid_next = 1'b1;
                    end else if (inf_in) begin
                        res_next = inv_i ? 16'h0000 : 16'h7F80;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // A core response on the limit cycle takes precedence over the timeout.
                if (valid_i) begin
                    res_next   = core_word;
                    state_next = DONE;
                end else if (count_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    res_next     = QNAN_PATTERN;
                    timeout_next = 1'b1;
                    invalid_next = 1'b1;
                    state_next   = DONE;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    invalid_next = 1'b0;
                    divzero_next = 1'b0;
                    timeout_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            inv_reg      <= 1'b0;
            sign_reg     <= 1'b0;
            ext_exp_reg  <= 8'h00;
            ext_mant_reg <= 8'h00;
            is_zero_reg  <= 1'b0;
            is_inf_reg   <= 1'b0;
            is_snan_reg  <= 1'b0;
            is_qnan_reg  <= 1'b0;
            res_reg      <= 16'h0000;
            invalid_reg  <= 1'b0;
            divzero_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            inv_reg      <= inv_next;
            sign_reg     <= sign_next;
            ext_exp_reg  <= ext_exp_next;
            ext_mant_reg <= ext_mant_next;
            is_zero_reg  <= is_zero_next;
            is_inf_reg   <= is_inf_next;
            is_snan_reg  <= is_snan_next;
            is_qnan_reg  <= is_qnan_next;
            res_reg      <= res_next;
            invalid_reg  <= invalid_next;
            divzero_reg  <= divzero_next;
            timeout_reg  <= timeout_next;
            count_reg    <= count_next;
        end
    end

    assign req_ready_o  = (state_reg == IDLE);
    assign doSqrt_o     = (state_reg == BUSY);
    assign res_valid_o  = (state_reg == DONE);
    assign invSqrt_o    = inv_reg;
    assign signum_op_o  = sign_reg;
    assign extExp_op_o  = ext_exp_reg;
    assign extMant_op_o = ext_mant_reg;
    assign isZero_op_o  = is_zero_reg;
    assign isInf_op_o   = is_inf_reg;
    assign isSNAN_op_o  = is_snan_reg;
    assign isQNAN_op_o  = is_qnan_reg;
    assign res_o        = res_reg;
    assign invalid_o    = invalid_reg;
    assign divzero_o    = divzero_reg;
    assign timeout_o    = timeout_reg;

endmodule

// File: doc/lamp_fpu_sqrt_ctrl.md
Name: lamp_fpu_sqrt_ctrl

Overview:
Issue/retire controller placed directly upstream and downstream of the lampFPU sqrt core. It accepts a packed bfloat16 operand (1/8/7) over a valid/ready handshake and classifies it. Special operands are resolved locally. For finite operands it drives the sqrt core's unpacked operand interface and holds doSqrt until the core's valid, then packs the core's result into a 16-bit word and returns it with exception flags over a second valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles spent waiting for core valid before abort; minimum 2.
QNAN_PATTERN, 16'h7FC0, canonical quiet-NaN result word.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  operand valid
req_ready_o  out  1  controller can accept operand
op_i  in  16  packed bfloat16 operand
inv_i  in  1  1 = 1/sqrt(x), 0 = sqrt(x)
doSqrt_o  out  1  start/hold request to core
invSqrt_o  out  1  to core invSqrt_i
signum_op_o  out  1  to core signum_op_i
extExp_op_o  out  8  to core extExp_op_i
extMant_op_o  out  8  to core extMant_op_i, hidden bit in MSB
isZero_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o  out  1 each  classification to core
valid_i  in  1  core result valid
s_res_i  in  1  core sign
e_res_i  in  8  core exponent
f_res_i  in  7  core fraction
res_valid_o  out  1  result valid
res_ready_i  in  1  consumer accepts result
res_o  out  16  packed result
invalid_o  out  1  invalid-operation flag, qualified by res_valid_o
divzero_o  out  1  divide-by-zero flag, qualified by res_valid_o
timeout_o  out  1  core did not respond, qualified by res_valid_o

Behaviour:
- Reset (synchronous, clk edge with rst=1): state IDLE. All outputs 0 except req_ready_o=1. Timeout counter 0. Reset overrides any state, including mid-BUSY; the core shares rst.
- FSM IDLE -> BUSY -> DONE -> IDLE. A special operand goes IDLE -> DONE.
- IDLE: req_ready_o=1. On req_valid_i&req_ready_o, register op_i and inv_i and classify:
  - exp=0xFF with frac!=0: NaN; frac[6]=1 is qNaN, otherwise sNaN.
  - exp=0xFF with frac=0: Inf.
  - exp=0 with frac=0: zero.
  - exp=0 with frac!=0: subnormal. extExp=1, hidden bit 0.
  - Otherwise normal: extExp=exp, extMant={1,frac}.
- Special resolution, in priority order (result registered, res_valid_o=1 on the next cycle, doSqrt_o never asserted):
  - sNaN: QNAN_PATTERN, invalid.
  - qNaN: QNAN_PATTERN, no flag.
  - ±0 with sqrt: ±0 (sign kept).
  - ±0 with invsqrt: 0x7F80, divzero.
  - Negative nonzero, including -Inf: QNAN_PATTERN, invalid.
  - +Inf with sqrt: 0x7F80.
  - +Inf with invsqrt: 0x0000.
- BUSY: core operand outputs are registered and stable for the whole state; doSqrt_o=1 and req_ready_o=0. On a cycle with valid_i=1, capture res_o={s_res_i,e_res_i,f_res_i}, drop doSqrt_o on the next cycle, go to DONE. res_valid_o rises one cycle after valid_i.
- Timeout: the counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES with no valid_i:
  - res_o=QNAN_PATTERN, timeout_o=1, invalid_o=1.
  - doSqrt_o deasserted, go to DONE.
  - valid_i arriving in the same cycle as the limit wins; no timeout is reported.
- DONE: res_valid_o=1. res_o and the flags are held stable until res_valid_o&res_ready_i. On that cycle go to IDLE, and clear res_valid_o and the flags on the next cycle. req_ready_o=0 throughout DONE; there is no overlap of successive operations.
- valid_i outside BUSY is ignored.
- Throughput: one operation in flight.
- Minimum latency for a special operand: accept at cycle N, result at N+1.

Optional Feature:
LAMP_SQRT_CTRL_FTZ_EN:
- Defined: a subnormal input is treated as zero of the same sign, so its special result follows the zero rules, including divzero for invsqrt.
- Core results with e_res_i=0 are forced to {s_res_i,15'b0}.
- Undefined: subnormals are forwarded to the core with extExp=1 and hidden bit 0. Core results pass through unmodified.

Test Plan:
- op_i=16'h4080 (4.0), inv_i=0, core model returns 0/0x80/0x00:
  - Core sees extExp_op_o=0x81, extMant_op_o=0x80, doSqrt_o high until valid_i.
  - res_o=16'h4000, no flags.
- op_i=16'h4080, inv_i=1, core returns 0/0x7E/0x00:
  - invSqrt_o=1.
  - res_o=16'h3F00.
- op_i=16'hBF80 (-1.0): doSqrt_o never high; res_o=16'h7FC0 and invalid_o=1 one cycle after accept. op_i=16'h0000 with inv_i=1: res_o=16'h7F80, divzero_o=1.
- Backpressure:
  - res_ready_i held low 3 cycles in DONE: res_o and flags stable, req_ready_o=0.
  - A req_valid_i presented meanwhile is not accepted until the cycle after the handshake.
- Core never asserts valid_i, TIMEOUT_CYCLES=64: after 64 BUSY cycles res_o=16'h7FC0, timeout_o=1, doSqrt_o=0.
- Reset mid-operation: rst=1 for one cycle during BUSY. Next cycle: state IDLE, doSqrt_o=0, res_valid_o=0, req_ready_o=1; a new 4.0 request then completes normally.
